// File: rtl/widen_accumulate_stage.sv
// widen_accumulate_stage
//   Registered stage behind the conditional/widening-cast block. Each accepted
//   beat contributes in_wide + zero-extended in_narrow. The stage sums
//   FRAME_LEN beats and then holds the frame result over a valid/ready
//   handshake.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      upstream beat valid
//   in_ready      stage can accept a beat (state only, low during reset)
//   in_narrow     32-bit upstream conditional result, unsigned
//   in_wide       64-bit upstream widened result, unsigned
//   out_valid     frame result valid
//   out_ready     downstream accepts the result
//   out_sum       accumulated sum, modulo 2^64
//   out_trunc32   low 32 bits of out_sum
//   out_sat32     out_sum saturated to 32 bits (unsigned)
//   out_overflow  sticky 64-bit carry-out seen during this frame
//   out_beats     beats accepted in the current frame
module widen_accumulate_stage #(
   parameter int unsigned FRAME_LEN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_narrow,
   input  logic [63:0] in_wide,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_sum,
   output logic [31:0] out_trunc32,
   output logic [31:0] out_sat32,
   output logic        out_overflow,
   output logic [7:0]  out_beats
);

   localparam logic [7:0] FRAME_LEN_B = 8'(FRAME_LEN);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t      state, state_nxt;
   logic [63:0] acc;
   logic        ovf;
   logic [7:0]  cnt;

   logic        beat_acc, xfer;
   logic [63:0] term, acc_sum;
   logic        c_term, c_acc;
   logic [7:0]  cnt_inc;

   // Two chained 65-bit adds; the top bit of each is its carry-out.
   always_comb begin
      {c_term, term}   = {1'b0, in_wide} + {33'b0, in_narrow};
      {c_acc, acc_sum} = {1'b0, acc} + {1'b0, term};
      cnt_inc          = cnt + 8'd1;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   // IDLE and ACCUM behave the same on a beat: cnt is 0 in IDLE, so
   // cnt_inc == FRAME_LEN also covers the FRAME_LEN == 1 case.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, ACCUM: if (beat_acc) state_nxt = (cnt_inc == FRAME_LEN_B) ? DONE : ACCUM;
         DONE:        if (xfer)     state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // in_ready depends on state (and reset) only, never on out_ready.
   always_comb begin
      in_ready  = !rst && (state != DONE);
      out_valid = (state == DONE);
      beat_acc  = in_valid && in_ready;
      xfer      = out_valid && out_ready;
   end

   // ---------------- datapath ----------------
   // acc/cnt/ovf are already zero on entry to IDLE, so the first beat needs
   // no special case. Transfer clears them on the same edge that leaves DONE.
   always_ff @(posedge clk) begin
      if (rst || xfer) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (beat_acc) begin
         acc <= acc_sum;
         cnt <= cnt_inc;
         ovf <= ovf | c_term | c_acc;
      end
   end

   assign out_sum      = acc;
   assign out_beats    = cnt;
   assign out_overflow = ovf;
   assign out_trunc32  = acc[31:0];
   assign out_sat32    = (ovf || (acc[63:32] != 32'd0)) ? 32'hFFFF_FFFF : acc[31:0];

endmodule

// File: tb/tb_widen_accumulate_stage.sv
module tb_widen_accumulate_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   // FRAME_LEN = 4 instance
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_overflow;
   logic [31:0] in_narrow = '0, out_trunc32, out_sat32;
   logic [63:0] in_wide = '0, out_sum;
   logic [7:0]  out_beats;

   // FRAME_LEN = 1 instance
   logic        v1 = 1'b0, r1, ov1, ordy1 = 1'b0, of1;
   logic [31:0] n1 = '0, t1, s1;
   logic [63:0] w1 = '0, sum1;
   logic [7:0]  b1;

   int cmp = 0;
   int mis = 0;

   always #5 clk = ~clk;

   widen_accumulate_stage #(.FRAME_LEN(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_narrow(in_narrow), .in_wide(in_wide), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_trunc32(out_trunc32),
      .out_sat32(out_sat32), .out_overflow(out_overflow), .out_beats(out_beats));

   widen_accumulate_stage #(.FRAME_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
      .in_narrow(n1), .in_wide(w1), .out_valid(ov1),
      .out_ready(ordy1), .out_sum(sum1), .out_trunc32(t1),
      .out_sat32(s1), .out_overflow(of1), .out_beats(b1));

   // advance one clock; outputs are sampled 1ns after the edge
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic beat(input logic [31:0] n, input logic [63:0] w);
      in_valid = 1'b1; in_narrow = n; in_wide = w;
      step();
      in_valid = 1'b0; in_narrow = '0; in_wide = '0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      cmp++; if (out_valid !== 1'b0) begin mis++; $display("FAIL drain_valid got=%0b exp=0", out_valid); end
      cmp++; if (out_overflow !== 1'b0) begin mis++; $display("FAIL drain_ovf got=%0b exp=0", out_overflow); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      cmp++; if (in_ready !== 1'b0) begin mis++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
      cmp++; if (out_valid !== 1'b0) begin mis++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
      cmp++; if (out_sum !== 64'h0) begin mis++; $display("FAIL rst_sum got=%h exp=0", out_sum); end
      cmp++; if (out_sat32 !== 32'h0) begin mis++; $display("FAIL rst_sat got=%h exp=0", out_sat32); end
      cmp++; if (out_beats !== 8'd0) begin mis++; $display("FAIL rst_beats got=%0d exp=0", out_beats); end
      rst = 1'b0;
      #1;
      cmp++; if (in_ready !== 1'b1) begin mis++; $display("FAIL rst_release_ready got=%0b exp=1", in_ready); end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 3; i++) beat(32'h10, 64'h100);
      cmp++; if (out_valid !== 1'b0) begin mis++; $display("FAIL basic_early_valid got=%0b exp=0", out_valid); end
      cmp++; if (out_beats !== 8'd3) begin mis++; $display("FAIL basic_beats3 got=%0d exp=3", out_beats); end
      beat(32'h10, 64'h100);
      cmp++; if (out_valid !== 1'b1) begin mis++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
      cmp++; if (in_ready !== 1'b0) begin mis++; $display("FAIL basic_in_ready got=%0b exp=0", in_ready); end
      cmp++; if (out_sum !== 64'h440) begin mis++; $display("FAIL basic_sum got=%h exp=440", out_sum); end
      cmp++; if (out_trunc32 !== 32'h440) begin mis++; $display("FAIL basic_trunc got=%h exp=440", out_trunc32); end
      cmp++; if (out_sat32 !== 32'h440) begin mis++; $display("FAIL basic_sat got=%h exp=440", out_sat32); end
      cmp++; if (out_overflow !== 1'b0) begin mis++; $display("FAIL basic_ovf got=%0b exp=0", out_overflow); end
      cmp++; if (out_beats !== 8'd4) begin mis++; $display("FAIL basic_beats got=%0d exp=4", out_beats); end
      drain();
   endtask

   task automatic test_width_cross();
      for (int i = 0; i < 4; i++) beat(32'hFFFF_FFFF, 64'h1);
      cmp++; if (out_sum !== 64'h4_0000_0000) begin mis++; $display("FAIL wx_sum got=%h exp=400000000", out_sum); end
      cmp++; if (out_trunc32 !== 32'h0) begin mis++; $display("FAIL wx_trunc got=%h exp=0", out_trunc32); end
      cmp++; if (out_sat32 !== 32'hFFFF_FFFF) begin mis++; $display("FAIL wx_sat got=%h exp=ffffffff", out_sat32); end
      cmp++; if (out_overflow !== 1'b0) begin mis++; $display("FAIL wx_ovf got=%0b exp=0", out_overflow); end
      drain();
   endtask

   task automatic test_wrap();
      beat(32'h2, 64'hFFFF_FFFF_FFFF_FFFF);
      cmp++; if (out_overflow !== 1'b1) begin mis++; $display("FAIL wrap_ovf_early got=%0b exp=1", out_overflow); end
      for (int i = 0; i < 3; i++) beat(32'h0, 64'h0);
      cmp++; if (out_sum !== 64'h1) begin mis++; $display("FAIL wrap_sum got=%h exp=1", out_sum); end
      cmp++; if (out_overflow !== 1'b1) begin mis++; $display("FAIL wrap_ovf got=%0b exp=1", out_overflow); end
      cmp++; if (out_sat32 !== 32'hFFFF_FFFF) begin mis++; $display("FAIL wrap_sat got=%h exp=ffffffff", out_sat32); end
      cmp++; if (out_trunc32 !== 32'h1) begin mis++; $display("FAIL wrap_trunc got=%h exp=1", out_trunc32); end
      drain();
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 4; i++) beat(32'h1, 64'h2);
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         in_narrow = 32'h55 + c; in_wide = 64'h1000 + c;
         step();
         cmp++; if (out_valid !== 1'b1) begin mis++; $display("FAIL bp_valid c=%0d got=%0b exp=1", c, out_valid); end
         cmp++; if (out_sum !== 64'hC) begin mis++; $display("FAIL bp_sum c=%0d got=%h exp=c", c, out_sum); end
         cmp++; if (out_beats !== 8'd4) begin mis++; $display("FAIL bp_beats c=%0d got=%0d exp=4", c, out_beats); end
         cmp++; if (in_ready !== 1'b0) begin mis++; $display("FAIL bp_in_ready c=%0d got=%0b exp=0", c, in_ready); end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      cmp++; if (out_valid !== 1'b0) begin mis++; $display("FAIL bp_rel_valid got=%0b exp=0", out_valid); end
      cmp++; if (out_sum !== 64'h0) begin mis++; $display("FAIL bp_rel_sum got=%h exp=0", out_sum); end
      cmp++; if (in_ready !== 1'b1) begin mis++; $display("FAIL bp_rel_ready got=%0b exp=1", in_ready); end
      cmp++; if (out_beats !== 8'd0) begin mis++; $display("FAIL bp_rel_beats got=%0d exp=0", out_beats); end
   endtask

   task automatic test_reset_mid_frame();
      beat(32'h9, 64'h9);
      beat(32'h9, 64'h9);
      cmp++; if (out_beats !== 8'd2) begin mis++; $display("FAIL rmf_beats2 got=%0d exp=2", out_beats); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      cmp++; if (out_sum !== 64'h0) begin mis++; $display("FAIL rmf_sum got=%h exp=0", out_sum); end
      cmp++; if (out_beats !== 8'd0) begin mis++; $display("FAIL rmf_beats got=%0d exp=0", out_beats); end
      cmp++; if (out_valid !== 1'b0) begin mis++; $display("FAIL rmf_valid got=%0b exp=0", out_valid); end
      for (int i = 0; i < 4; i++) beat(32'h1, 64'h1);
      cmp++; if (out_valid !== 1'b1) begin mis++; $display("FAIL rmf_post_valid got=%0b exp=1", out_valid); end
      cmp++; if (out_sum !== 64'h8) begin mis++; $display("FAIL rmf_post_sum got=%h exp=8", out_sum); end
      drain();
   endtask

   task automatic test_bubbles();
      beat(32'h3, 64'h4);
      step(); step();
      cmp++; if (out_beats !== 8'd1) begin mis++; $display("FAIL bub_beats1 got=%0d exp=1", out_beats); end
      beat(32'h3, 64'h4);
      cmp++; if (out_beats !== 8'd2) begin mis++; $display("FAIL bub_beats2 got=%0d exp=2", out_beats); end
      step();
      cmp++; if (out_sum !== 64'hE) begin mis++; $display("FAIL bub_sum2 got=%h exp=e", out_sum); end
      beat(32'h3, 64'h4);
      beat(32'h3, 64'h4);
      cmp++; if (out_valid !== 1'b1) begin mis++; $display("FAIL bub_valid got=%0b exp=1", out_valid); end
      cmp++; if (out_sum !== 64'h1C) begin mis++; $display("FAIL bub_sum got=%h exp=1c", out_sum); end
      drain();
   endtask

   task automatic test_frame_len1();
      cmp++; if (ov1 !== 1'b0) begin mis++; $display("FAIL fl1_idle_valid got=%0b exp=0", ov1); end
      v1 = 1'b1; n1 = 32'h5; w1 = 64'h7;
      step();
      v1 = 1'b0; n1 = '0; w1 = '0;
      cmp++; if (ov1 !== 1'b1) begin mis++; $display("FAIL fl1_valid got=%0b exp=1", ov1); end
      cmp++; if (sum1 !== 64'hC) begin mis++; $display("FAIL fl1_sum got=%h exp=c", sum1); end
      cmp++; if (b1 !== 8'd1) begin mis++; $display("FAIL fl1_beats got=%0d exp=1", b1); end
      cmp++; if (r1 !== 1'b0) begin mis++; $display("FAIL fl1_in_ready got=%0b exp=0", r1); end
      ordy1 = 1'b1;
      step();
      ordy1 = 1'b0;
      cmp++; if (ov1 !== 1'b0) begin mis++; $display("FAIL fl1_drain got=%0b exp=0", ov1); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_width_cross();
      test_wrap();
      test_backpressure();
      test_reset_mid_frame();
      test_bubbles();
      test_frame_len1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
      $finish;
   end

endmodule

// File: doc/widen_accumulate_stage.md
Name: widen_accumulate_stage

Overview:
- Registered stage directly downstream of the conditional/widening-cast block.
- Per beat, consumes that block's 32-bit conditional result and 64-bit explicitly widened result, zero-extends the narrow operand to 64 bits and adds both.
- Accumulates FRAME_LEN beats, then presents the 64-bit sum plus truncated and saturated 32-bit views over a valid/ready handshake.

Parameters:
- FRAME_LEN, 4: beats accumulated per frame; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- in_narrow  input  32  upstream conditional result, treated unsigned
- in_wide  input  64  upstream widened result, treated unsigned
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  64  accumulated sum, modulo 2^64
- out_trunc32  output  32  out_sum[31:0]
- out_sat32  output  32  unsigned saturation of out_sum to 32 bits
- out_overflow  output  1  sticky per-frame 64-bit carry-out flag
- out_beats  output  8  beats accepted in the current frame

Behaviour:
- One clock; synchronous active-high reset.
- Beat acceptance: a beat is accepted when in_valid && in_ready is high at a clk edge. Result transfer occurs when out_valid && out_ready is high at a clk edge.
- Per-beat term: term = in_wide + {32'b0, in_narrow}, 64-bit wrap.
- Accumulation: acc_next = acc + term, 64-bit wrap. A carry-out from either addition sets overflow; overflow stays set until the frame is consumed.
- Registers: acc, overflow, beat count and state are registers. out_sum, out_beats and out_overflow drive directly from those registers.
- out_trunc32 = acc[31:0].
- out_sat32 = 32'hFFFF_FFFF if overflow is set or acc[63:32] != 0; otherwise acc[31:0].
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: in_ready=1, out_valid=0, acc=0, count=0, overflow=0. An accepted beat moves to ACCUM, or to DONE if FRAME_LEN==1.
  - ACCUM: in_ready=1. Each accepted beat increments count. On the beat that makes count==FRAME_LEN, move to DONE.
  - DONE: in_ready=0, out_valid=1. out_sum, out_trunc32, out_sat32, out_overflow and out_beats hold stable until transfer. On transfer, move to IDLE and clear acc, count and overflow in the same edge.
- Latency: out_valid rises on the clock edge that accepts the final beat, so it is visible the cycle after that beat. There is no combinational path from in_* to out_*.
- Bubbles: cycles with in_valid=0 change nothing.
- Backpressure in DONE: in_valid is ignored and no beat is lost, because in_ready=0 tells upstream to hold.
- Input and output events can never overlap within a frame, since in_ready=0 whenever out_valid=1. The first beat of the next frame can be accepted one cycle after transfer.
- in_ready is combinational from state only, never from out_ready.
- Reset (at any time, including mid-frame or in DONE):
  - Next state IDLE.
  - acc=0, overflow=0, count=0, out_valid=0.
  - out_sum=0, out_trunc32=0, out_sat32=0, out_overflow=0, out_beats=0.
  - in_ready is forced 0 while rst is high.
  - Partial-frame data is discarded.
- count wrap cannot occur, because FRAME_LEN ≤ 255.

Test Plan:
- Basic frame (FRAME_LEN=4): 4 back-to-back beats with in_narrow=32'h10 and in_wide=64'h100.
  - out_valid rises the cycle after the 4th beat.
  - out_sum=64'h440, out_trunc32=32'h440, out_sat32=32'h440, out_overflow=0, out_beats=4.
- Width crossing: 4 beats with in_narrow=32'hFFFF_FFFF and in_wide=64'h1 (term 64'h1_0000_0000 each).
  - out_sum=64'h4_0000_0000, out_trunc32=0, out_sat32=32'hFFFF_FFFF, out_overflow=0.
- 64-bit wrap: beat 1 with in_wide=64'hFFFF_FFFF_FFFF_FFFF and in_narrow=2, then 3 beats of zeros.
  - out_sum=64'h1, out_overflow=1, out_sat32=32'hFFFF_FFFF, out_trunc32=32'h1.
- Backpressure: complete a frame and hold out_ready=0 for 5 cycles while driving in_valid=1 with new data.
  - out_valid and all out_* stay stable; in_ready=0; no beat counted.
  - Raise out_ready: next cycle out_valid=0, out_sum=0, in_ready=1.
- Reset mid-frame: accept 2 beats, pulse rst for 1 cycle.
  - All outputs 0, out_beats=0.
  - 4 subsequent beats of in_narrow=1, in_wide=1 yield out_sum=64'h8.
- Bubbles and FRAME_LEN=1: interleave in_valid=0 gaps and confirm out_beats only advances on accepted beats.
  - With FRAME_LEN=1, a single beat (in_narrow=5, in_wide=7) gives out_valid on the next cycle with out_sum=64'hC.
